// File: rtl/gift_key_cache_if.sv
// rtl/gift_key_cache_if.sv - key-load, stream-request and round-key stream bundle for gift_key_cache
//
// Purpose: groups every non-clock signal of the GIFT-128 round-key cache.
//   master : the key-load / request side (drives the in* signals)
//   slave  : the cache itself (drives the out* signals)
// Signals:
//   inKeyWr, inKeySlot, inKeyData          load a 128-bit master key into a slot
//   inReqStart, inReqSlot, inReqDir        request a stream of one slot's round keys
//   inReqAbort                             cancel the active stream
//   outRkValid, outRkData, outRkIdx,       streamed round-key word, its round index
//   outRkLast                              and the final-word marker
//   outSlotValid                           per-slot expanded-and-usable flags
//   outBusy, outReqErr                     controller busy, rejected-request pulse

interface gift_key_cache_if #(
  parameter int SLOTS = 4,
  parameter int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
);
  logic             inKeyWr;
  logic [SW-1:0]    inKeySlot;
  logic [127:0]     inKeyData;
  logic             inReqStart;
  logic [SW-1:0]    inReqSlot;
  logic             inReqDir;
  logic             inReqAbort;
  logic             outRkValid;
  logic [135:0]     outRkData;
  logic [5:0]       outRkIdx;
  logic             outRkLast;
  logic [SLOTS-1:0] outSlotValid;
  logic             outBusy;
  logic             outReqErr;

  modport master (
    output inKeyWr, inKeySlot, inKeyData,
    output inReqStart, inReqSlot, inReqDir, inReqAbort,
    input  outRkValid, outRkData, outRkIdx, outRkLast,
    input  outSlotValid, outBusy, outReqErr
  );

  modport slave (
    input  inKeyWr, inKeySlot, inKeyData,
    input  inReqStart, inReqSlot, inReqDir, inReqAbort,
    output outRkValid, outRkData, outRkIdx, outRkLast,
    output outSlotValid, outBusy, outReqErr
  );
endinterface

// File: rtl/gift_key_cache.sv
// rtl/gift_key_cache.sv - multi-slot GIFT-128 round-key cache with forward/reverse streaming
//
// Purpose: expands a loaded 128-bit key into ROUNDS round-key states plus round
// constants, keeps them in a single-port RAM (one region per slot) and streams a
// slot's words one per cycle in encrypt (0..ROUNDS-1) or decrypt (ROUNDS-1..0) order.
// Ports:
//   inClk   clock, all state on the rising edge
//   inRstN  asynchronous active-low reset
//   bus     gift_key_cache_if slave modport (key load, stream request, round-key
//           stream, slot-valid flags, busy and request-error outputs)
// Stream word format: outRkData = {2'b00, const[5:0], keystate[127:0]}.

module gift_key_cache #(
  parameter int ROUNDS = 40,
  parameter int SLOTS  = 4
) (
  input  logic              inClk,
  input  logic              inRstN,
  gift_key_cache_if.slave   bus
);

  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int DEPTH = SLOTS * ROUNDS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2
  } stateType;

  stateType         state;
  logic [5:0]       cnt;          // rounds written (EXPAND) or reads issued (STREAM)
  logic [SW-1:0]    slotReg;
  logic             dirReg;
  logic [133:0]     work;         // {const[5:0], keystate[127:0]} of the round being written
  logic [SLOTS-1:0] slotValid;
  logic             rkValid;
  logic [5:0]       rkIdx;
  logic             rkLast;
  logic             reqErr;

  logic [127:0]     nextKey;
  logic [5:0]       nextConst;
  logic [5:0]       roundSel;
  logic             issue;
  logic             keySlotOk;
  logic             reqSlotOk;
  logic [AW-1:0]    ramAddr;
  logic             ramWe;
  logic [135:0]     ramQ;
  logic [135:0]     mem [DEPTH];

  // Key schedule: words k7..k0 (k7 = bits 127:112) become
  // rotr(k1,2) || rotr(k0,12) || k7 || k6 || k5 || k4 || k3 || k2.
  assign nextKey = {work[17:16], work[31:18],    // k1 rotated right by 2
                    work[11:0],  work[15:12],    // k0 rotated right by 12
                    work[127:32]};               // k7..k2 shift down two words
  assign nextConst = {work[132:128], work[133] ^ work[132] ^ 1'b1};

  // Non-power-of-two slot counts leave unused slot codes; those are never accepted.
  assign keySlotOk = (int'(bus.inKeySlot) < SLOTS);
  assign reqSlotOk = (int'(bus.inReqSlot) < SLOTS);

  assign issue    = (state == STREAM);
  assign roundSel = (issue && dirReg) ? (LAST_RND - cnt) : cnt;
  assign ramWe    = (state == EXPAND);
  assign ramAddr  = AW'(int'(slotReg) * ROUNDS + int'(roundSel));

  // Single-port RAM, synchronous read, contents deliberately left unreset.
  always_ff @(posedge inClk) begin
    if (ramWe) begin
      mem[ramAddr] <= {2'b00, work};
    end
    if (issue) begin
      ramQ <= mem[ramAddr];
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state     <= IDLE;
      cnt       <= '0;
      slotReg   <= '0;
      dirReg    <= 1'b0;
      work      <= '0;
      slotValid <= '0;
      rkValid   <= 1'b0;
      rkIdx     <= '0;
      rkLast    <= 1'b0;
      reqErr    <= 1'b0;
    end else begin
      // Stream outputs are the read-issue signals one cycle late, matching RAM latency.
      // A read issued in the abort cycle still emits, but never as the last word.
      rkValid <= issue;
      rkIdx   <= issue ? roundSel : 6'd0;
      rkLast  <= issue && (cnt == LAST_RND) && !bus.inReqAbort;
      reqErr  <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.inKeyWr && keySlotOk) begin
            // Key load has priority; a simultaneous request is rejected.
            state                   <= EXPAND;
            slotReg                 <= bus.inKeySlot;
            slotValid[bus.inKeySlot] <= 1'b0;
            work                    <= {6'h01, bus.inKeyData};
            reqErr                  <= bus.inReqStart;
          end else if (bus.inReqStart) begin
            if (reqSlotOk && slotValid[bus.inReqSlot]) begin
              state   <= STREAM;
              slotReg <= bus.inReqSlot;
              dirReg  <= bus.inReqDir;
            end else begin
              reqErr <= 1'b1;
            end
          end
        end

        EXPAND: begin
          // Round cnt is written this cycle from work; advance to the next round.
          work <= {nextConst, nextKey};
          cnt  <= cnt + 6'd1;
          if (cnt == LAST_RND) begin
            slotValid[slotReg] <= 1'b1;
            state              <= IDLE;
            cnt                <= '0;
          end
        end

        STREAM: begin
          cnt <= cnt + 6'd1;
          if (bus.inReqAbort || (cnt == LAST_RND)) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.outRkValid   = rkValid;
  assign bus.outRkData    = rkValid ? ramQ : '0;
  assign bus.outRkIdx     = rkIdx;
  assign bus.outRkLast    = rkLast;
  assign bus.outSlotValid = slotValid;
  assign bus.outBusy      = (state != IDLE);
  assign bus.outReqErr    = reqErr;

endmodule

// File: doc/gift_key_cache.md
# gift_key_cache

Multi-slot GIFT-128 round-key cache: expands a loaded 128-bit key into all round-key states and round constants, and stores them in an internal single-port RAM. On request it streams them one per cycle in forward (encrypt) or reverse (decrypt) order. It sits between the key-load interface and the encrypt/decrypt round datapaths. It generalises the decryptor's single-key precompute memory to several key slots, a configurable round count and both stream directions.

## Interface
Parameters:
- ROUNDS, 40, rounds expanded per key; legal 1..63
- SLOTS, 4, number of independent key slots; legal 1..16
- SW, derived, max(1, $clog2(SLOTS)), slot index width

Ports:
- inClk  in  1  clock; all state updates on rising edge
- inRstN  in  1  reset, asynchronous, active-low
- inKeyWr  in  1  load-key strobe, single cycle
- inKeySlot  in  SW  target slot for load
- inKeyData  in  128  master key K
- inReqStart  in  1  stream-request strobe
- inReqSlot  in  SW  slot to stream
- inReqDir  in  1  0 = rounds 0..ROUNDS-1, 1 = ROUNDS-1..0
- inReqAbort  in  1  cancel active stream
- outRkValid  out  1  round-key word valid
- outRkData  out  136  {const[5:0], keystate[127:0]}
- outRkIdx  out  6  round index of outRkData
- outRkLast  out  1  final word of stream
- outSlotValid  out  SLOTS  per-slot expanded-and-usable flags
- outBusy  out  1  FSM not IDLE
- outReqErr  out  1  one-cycle pulse: request rejected

## Operation
- RAM is SLOTS*ROUNDS x 136 bits, single port, synchronous read with 1-cycle latency. Address = slot*ROUNDS + round. RAM contents are not reset.
- Key-state update: state k7..k0 (16-bit words, k7 = bits 127:112) becomes (k1>>>2)||(k0>>>12)||k7||k6||k5||k4||k3||k2.
- Constant update: c becomes {c[4:0], c[5]^c[4]^1}. Round 0 uses c = 6'h01 and keystate = K.
- FSM has three states: IDLE, EXPAND, STREAM.
- IDLE to EXPAND on inKeyWr:
  - Clear outSlotValid[inKeySlot] and load the working register with {6'h01, K}.
  - Write round r on EXPAND cycle r, then update the working register.
  - After round ROUNDS-1 is written: set the slot-valid bit and return to IDLE.
- IDLE to STREAM on inReqStart when outSlotValid[inReqSlot] = 1:
  - Issue ROUNDS reads in direction order, one per cycle.
  - Return to IDLE on the cycle after the last issue.
  - outRkValid/outRkIdx/outRkLast are the read-issue signals delayed one cycle.
- inReqStart with an invalid slot: pulse outReqErr and stay IDLE.
- inKeyWr or inReqStart while not IDLE: ignored, no error.
- inKeyWr and inReqStart in the same IDLE cycle: key load wins; request dropped with outReqErr.
- inReqAbort in STREAM: stop issuing, go to IDLE next cycle. The already-issued read still emits one valid word, with outRkLast = 0. inReqAbort outside STREAM has no effect.
- Reset mid-EXPAND: the slot stays invalid. Reset mid-STREAM: no further valid words.

## Timing
- Reset values: all outputs 0; outSlotValid = 0; FSM IDLE.
- Load strobe sampled at edge T:
  - outBusy high T+1 .. T+ROUNDS.
  - Round r written at edge T+1+r.
  - Slot valid and outBusy low from T+ROUNDS+1.
  - A load needs ROUNDS+1 cycles total before a new strobe is accepted.
- Stream start sampled at edge T:
  - Words valid on cycles T+2 .. T+ROUNDS+1, contiguous with no gaps.
  - outRkLast coincides with the final word.
  - outBusy high T+1 .. T+ROUNDS.
- A new start sampled in the first IDLE cycle is legal. Its words follow the previous stream's last word with one idle cycle between.
- outReqErr is asserted in the cycle after the rejected strobe, for exactly one cycle.

## Test plan
- Reset, then load K = 0 into slot 0; stream slot 0, forward:
  - 40 words; keystate is 0 in every word.
  - Constants 01, 03, 07, 0F, ... ; idx 39 has const 1A.
  - outRkLast only on idx 39; first word exactly 2 cycles after the start strobe.
- Load K with bits 15:0 = 16'h0001 (rest 0) into slot 2; stream forward:
  - idx 0 data = {6'h01, K}.
  - idx 1 keystate = 128'h0000_0010_0000_0000_0000_0000_0000_0000, const 03.
- Stream the same slot with inReqDir = 1: idx sequence is 39..0, each data word identical to the forward run at the same idx.
- Request on unloaded slot 3; also request while EXPAND is running:
  - Unloaded slot: outReqErr pulse, no valid words.
  - During EXPAND: ignored, no error.
- Simultaneous inKeyWr (slot 1) and inReqStart (slot 0) in IDLE: slot 1 expands, outReqErr pulses, no stream.
- Assert inReqAbort on the 5th stream cycle: exactly one further word, outRkLast never asserts, outBusy low next cycle. Assert inRstN low mid-EXPAND: all outputs 0 immediately, outSlotValid = 0.
